// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage sequencer for the pipelined LC-3b datapath.
// Decodes LDR/LDB/LDI/STR/STB/STI from the MEM-stage opcode. It drives the data-memory port,
// steers byte lanes and runs the two-access indirect sequence. It stalls upstream stages until
// the access completes.
//
// Ports:
//   clk, reset        pipeline clock, asynchronous active-high reset
//   valid_in, opcode  MEM-stage instruction valid and lc3b opcode
//   addr, store_data  effective address and store source value
//   dmem_rdata/resp   data-memory read data and per-access completion
//   dmem_address/read/write/wmask/wdata  data-memory request
//   load_data         registered load result to WB
//   done              one-cycle pulse when a memory instruction completes
//   stall             freezes upstream pipeline registers
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [3:0]  opcode,
  input  logic [15:0] addr,
  input  logic [15:0] store_data,
  input  logic [15:0] dmem_rdata,
  input  logic        dmem_resp,
  output logic [15:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [1:0]  dmem_wmask,
  output logic [15:0] dmem_wdata,
  output logic [15:0] load_data,
  output logic        done,
  output logic        stall
);

  localparam logic [3:0] OpLdb = 4'b0010;
  localparam logic [3:0] OpStb = 4'b0011;
  localparam logic [3:0] OpLdr = 4'b0110;
  localparam logic [3:0] OpStr = 4'b0111;
  localparam logic [3:0] OpLdi = 4'b1010;
  localparam logic [3:0] OpSti = 4'b1011;

  typedef enum logic [1:0] {StIdle, StInd, StAcc, StDone} state_e;

  state_e      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] sdata_q, sdata_d;
  logic [15:0] ptr_q, ptr_d;
  logic [15:0] load_q, load_d;

  logic       mem_op;
  logic       op_ind, op_byte, op_load;
  logic [7:0] byte_sel;

  assign mem_op  = valid_in && (opcode inside {OpLdr, OpLdb, OpLdi, OpStr, OpStb, OpSti});
  assign op_ind  = (op_q == OpLdi) || (op_q == OpSti);
  assign op_byte = (op_q == OpLdb) || (op_q == OpStb);
  assign op_load = (op_q == OpLdr) || (op_q == OpLdb) || (op_q == OpLdi);
  assign byte_sel = addr_q[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    sdata_d      = sdata_q;
    ptr_d        = ptr_q;
    load_d       = load_q;
    dmem_address = 16'h0000;
    dmem_read    = 1'b0;
    dmem_write   = 1'b0;
    dmem_wmask   = 2'b00;
    dmem_wdata   = 16'h0000;
    done         = 1'b0;
    stall        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mem_op) begin
          stall   = 1'b1;
          op_d    = opcode;
          addr_d  = addr;
          sdata_d = store_data;
          state_d = ((opcode == OpLdi) || (opcode == OpSti)) ? StInd : StAcc;
        end
      end
      StInd: begin
        stall        = 1'b1;
        dmem_read    = 1'b1;
        dmem_address = {addr_q[15:1], 1'b0};
        if (dmem_resp) begin
          ptr_d   = {dmem_rdata[15:1], 1'b0};
          state_d = StAcc;
        end
      end
      StAcc: begin
        stall = 1'b1;
        if (op_ind) begin
          dmem_address = ptr_q;
        end else if (op_byte) begin
          dmem_address = addr_q;
        end else begin
          dmem_address = {addr_q[15:1], 1'b0};
        end
        if (op_load) begin
          dmem_read = 1'b1;
        end else begin
          dmem_write = 1'b1;
          if (op_byte) begin
            // Byte store replicates into both lanes; the mask picks the lane.
            dmem_wdata = {sdata_q[7:0], sdata_q[7:0]};
            dmem_wmask = addr_q[0] ? 2'b10 : 2'b01;
          end else begin
            dmem_wdata = sdata_q;
            dmem_wmask = 2'b11;
          end
        end
        if (dmem_resp) begin
          state_d = StDone;
          if (op_load) begin
            load_d = op_byte ? {{8{byte_sel[7]}}, byte_sel} : dmem_rdata;
          end
        end
      end
      StDone: begin
        // valid_in is not sampled here so the finishing instruction is not re-accepted.
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      op_q    <= 4'h0;
      addr_q  <= 16'h0000;
      sdata_q <= 16'h0000;
      ptr_q   <= 16'h0000;
      load_q  <= 16'h0000;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      ptr_q   <= ptr_d;
      load_q  <= load_d;
    end
  end

  assign load_data = load_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: transaction-level reference model plus directed vectors.
module tb_mem_access_unit;

  localparam logic [3:0] OpAdd = 4'b0001;
  localparam logic [3:0] OpLdb = 4'b0010;
  localparam logic [3:0] OpStb = 4'b0011;
  localparam logic [3:0] OpLdr = 4'b0110;
  localparam logic [3:0] OpStr = 4'b0111;
  localparam logic [3:0] OpLdi = 4'b1010;
  localparam logic [3:0] OpSti = 4'b1011;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic [3:0]  opcode = 4'h0;
  logic [15:0] addr = 16'h0;
  logic [15:0] store_data = 16'h0;
  logic [15:0] dmem_rdata = 16'h0;
  logic        dmem_resp = 1'b0;
  logic [15:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [1:0]  dmem_wmask;
  logic [15:0] dmem_wdata;
  logic [15:0] load_data;
  logic        done;
  logic        stall;

  mem_access_unit dut (
    .clk          (clk),
    .reset        (reset),
    .valid_in     (valid_in),
    .opcode       (opcode),
    .addr         (addr),
    .store_data   (store_data),
    .dmem_rdata   (dmem_rdata),
    .dmem_resp    (dmem_resp),
    .dmem_address (dmem_address),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_wmask   (dmem_wmask),
    .dmem_wdata   (dmem_wdata),
    .load_data    (load_data),
    .done         (done),
    .stall        (stall)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  int done_total = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic bit is_mem(input logic [3:0] op);
    return op == OpLdr || op == OpLdb || op == OpLdi || op == OpStr || op == OpStb || op == OpSti;
  endfunction

  function automatic bit is_store(input logic [3:0] op);
    return op == OpStr || op == OpStb || op == OpSti;
  endfunction

  function automatic logic [15:0] sext8(input logic [7:0] b);
    return (b >= 8'd128) ? 16'(b) + 16'hFF00 : 16'(b);
  endfunction

  // Reference model: one outstanding instruction, a pending pointer fetch, then the data access.
  bit          m_busy = 0;
  bit          m_done = 0;
  bit          m_ptr = 0;
  logic [3:0]  m_op = 0;
  logic [15:0] m_a = 0;
  logic [15:0] m_sd = 0;
  logic [15:0] m_addr = 0;
  logic [15:0] m_load = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy <= 0;
      m_done <= 0;
      m_ptr  <= 0;
      m_load <= 0;
      m_addr <= 0;
    end else if (m_done) begin
      m_done <= 0;
    end else if (m_busy) begin
      if (dmem_resp) begin
        if (m_ptr) begin
          m_ptr  <= 0;
          m_addr <= dmem_rdata & 16'hFFFE;
        end else begin
          m_busy <= 0;
          m_done <= 1;
          if (m_op == OpLdb) m_load <= sext8(m_a[0] ? dmem_rdata[15:8] : dmem_rdata[7:0]);
          else if (m_op == OpLdr || m_op == OpLdi) m_load <= dmem_rdata;
        end
      end
    end else if (valid_in && is_mem(opcode)) begin
      m_busy <= 1;
      m_op   <= opcode;
      m_a    <= addr;
      m_sd   <= store_data;
      m_ptr  <= (opcode == OpLdi || opcode == OpSti);
      m_addr <= (opcode == OpLdb || opcode == OpStb) ? addr : (addr & 16'hFFFE);
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    logic        e_rd, e_wr;
    logic [1:0]  e_mask;
    logic [15:0] e_wdata;
    if (chk_en) begin
      e_rd    = m_busy && (m_ptr || !is_store(m_op));
      e_wr    = m_busy && !m_ptr && is_store(m_op);
      e_mask  = !e_wr ? 2'b00 : (m_op == OpStb) ? (m_a[0] ? 2'b10 : 2'b01) : 2'b11;
      e_wdata = !e_wr ? 16'h0 : (m_op == OpStb) ? {m_sd[7:0], m_sd[7:0]} : m_sd;
      chk("cyc_addr", dmem_address, m_busy ? m_addr : 16'h0);
      chk("cyc_read", 16'(dmem_read), 16'(e_rd));
      chk("cyc_write", 16'(dmem_write), 16'(e_wr));
      chk("cyc_wmask", 16'(dmem_wmask), 16'(e_mask));
      chk("cyc_wdata", dmem_wdata, e_wdata);
      chk("cyc_load", load_data, m_load);
      chk("cyc_done", 16'(done), 16'(m_done));
      chk("cyc_stall", 16'(stall),
          16'(m_busy || (!m_done && valid_in && is_mem(opcode))));
      if (done) done_total++;
    end
  end

  // Memory responder: per-access delay and read data come from queues.
  int          dlq[$];
  logic [15:0] rdq[$];
  logic [15:0] addr_log[$];
  bit          in_acc = 0;
  bit          force_resp = 0;
  int          wait_cnt = 0;
  int          cur_delay = 0;
  logic [15:0] last_wdata = 0;
  logic [1:0]  last_wmask = 0;
  logic        last_rd = 0;

  always @(negedge clk) begin
    if (force_resp) begin
      dmem_resp  = 1'b1;
      dmem_rdata = 16'hDEAD;
    end else if (dmem_read || dmem_write) begin
      if (!in_acc) begin
        in_acc    = 1;
        wait_cnt  = 0;
        cur_delay = 0;
        if (dlq.size() > 0) cur_delay = dlq.pop_front();
        addr_log.push_back(dmem_address);
      end
      if (dmem_write) begin
        last_wdata = dmem_wdata;
        last_wmask = dmem_wmask;
        last_rd    = dmem_read;
      end
      if (wait_cnt == cur_delay) begin
        dmem_resp  = 1'b1;
        dmem_rdata = 16'h0;
        if (rdq.size() > 0) dmem_rdata = rdq.pop_front();
        in_acc = 0;
      end else begin
        dmem_resp = 1'b0;
        wait_cnt++;
      end
    end else begin
      dmem_resp = 1'b0;
      in_acc    = 0;
    end
  end

  // Present an op until its done pulse; returns stall count, done cycle index, accept-cycle stall.
  task automatic run_op(input logic [3:0] op, input logic [15:0] a, input logic [15:0] sd,
                        output int stall_cnt, output int done_idx, output logic first_stall);
    valid_in    = 1'b1;
    opcode      = op;
    addr        = a;
    store_data  = sd;
    stall_cnt   = 0;
    done_idx    = -1;
    first_stall = 1'b0;
    addr_log.delete();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (i == 0) first_stall = stall;
      if (stall) stall_cnt++;
      if (done) begin
        done_idx = i;
        break;
      end
    end
    if (done_idx < 0) chk("op_timeout", 16'(op), 16'hFFFF);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
  endtask

  int   sc, di, d0;
  logic fs;
  bit   seen;

  initial begin
    #2 reset = 1'b1;
    chk_en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_addr", dmem_address, 16'h0);
    chk("rst_rw", {14'h0, dmem_read, dmem_write}, 16'h0);
    chk("rst_wmask", 16'(dmem_wmask), 16'h0);
    chk("rst_load", load_data, 16'h0);
    chk("rst_done_stall", {14'h0, done, stall}, 16'h0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // LDR, response on the first access cycle
    dlq = {0};
    rdq = {16'hBEEF};
    run_op(OpLdr, 16'h1003, 16'h0, sc, di, fs);
    chk("ldr_addr", addr_log.size() > 0 ? addr_log[0] : 16'hXXXX, 16'h1002);
    chk("ldr_load", load_data, 16'hBEEF);
    chk("ldr_done_idx", 16'(di), 16'd2);
    chk("ldr_stall_cnt", 16'(sc), 16'd2);

    // LDB, odd then even byte
    rdq = {16'h80FF};
    run_op(OpLdb, 16'h2001, 16'h0, sc, di, fs);
    chk("ldb_hi_load", load_data, 16'hFF80);
    chk("ldb_hi_addr", addr_log.size() > 0 ? addr_log[0] : 16'hXXXX, 16'h2001);
    rdq = {16'h80FF};
    run_op(OpLdb, 16'h2000, 16'h0, sc, di, fs);
    chk("ldb_lo_load", load_data, 16'hFFFF);

    // STB, then STR with the same data; load_data must hold
    run_op(OpStb, 16'h3001, 16'h1234, sc, di, fs);
    chk("stb_wdata", last_wdata, 16'h3434);
    chk("stb_wmask", 16'(last_wmask), 16'h2);
    chk("stb_read", 16'(last_rd), 16'h0);
    chk("stb_addr", addr_log.size() > 0 ? addr_log[0] : 16'hXXXX, 16'h3001);
    run_op(OpStr, 16'h3001, 16'h1234, sc, di, fs);
    chk("str_wmask", 16'(last_wmask), 16'h3);
    chk("str_wdata", last_wdata, 16'h1234);
    chk("str_addr", addr_log.size() > 0 ? addr_log[0] : 16'hXXXX, 16'h3000);
    chk("st_load_hold", load_data, 16'hFFFF);

    // LDI with two wait cycles on each access
    dlq = {2, 2};
    rdq = {16'h5001, 16'h00AA};
    d0 = done_total;
    run_op(OpLdi, 16'h4000, 16'h0, sc, di, fs);
    chk("ldi_ptr_addr", addr_log.size() > 0 ? addr_log[0] : 16'hXXXX, 16'h4000);
    chk("ldi_data_addr", addr_log.size() > 1 ? addr_log[1] : 16'hXXXX, 16'h5000);
    chk("ldi_load", load_data, 16'h00AA);
    chk("ldi_stall_cnt", 16'(sc), 16'd7);
    chk("ldi_done_idx", 16'(di), 16'd7);
    repeat (2) @(posedge clk);
    #1;
    chk("ldi_done_pulses", 16'(done_total - d0), 16'd1);

    // STI aborted by reset while the store is outstanding
    dlq = {0, 1000};
    rdq = {16'h6000};
    valid_in   = 1'b1;
    opcode     = OpSti;
    addr       = 16'h7000;
    store_data = 16'h5555;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (dmem_write) seen = 1;
    end
    chk("sti_write_seen", 16'(seen), 16'h1);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    valid_in = 1'b0;
    #1;
    chk("sti_rst_write", 16'(dmem_write), 16'h0);
    chk("sti_rst_read", 16'(dmem_read), 16'h0);
    chk("sti_rst_addr", dmem_address, 16'h0);
    chk("sti_rst_wdata", dmem_wdata, 16'h0);
    chk("sti_rst_wmask", 16'(dmem_wmask), 16'h0);
    chk("sti_rst_load", load_data, 16'h0);
    chk("sti_rst_done_stall", {14'h0, done, stall}, 16'h0);
    dlq.delete();
    rdq.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
    d0 = done_total;
    force_resp = 1;
    repeat (3) @(posedge clk);
    #1;
    force_resp = 0;
    chk("idle_resp_load", load_data, 16'h0);
    chk("idle_resp_rw", {14'h0, dmem_read, dmem_write}, 16'h0);
    chk("idle_resp_done", 16'(done_total - d0), 16'h0);

    // ADD passes through
    valid_in = 1'b1;
    opcode   = OpAdd;
    addr     = 16'h1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("add_stall_done", {14'h0, done, stall}, 16'h0);
    end
    @(posedge clk);
    #1;
    valid_in = 1'b0;

    // Back-to-back STR, STR
    d0 = done_total;
    run_op(OpStr, 16'h8000, 16'hA5A5, sc, di, fs);
    chk("b2b_first_done_idx", 16'(di), 16'd2);
    run_op(OpStr, 16'h8002, 16'h5A5A, sc, di, fs);
    chk("b2b_second_accept", 16'(fs), 16'h1);
    chk("b2b_second_done_idx", 16'(di), 16'd2);
    chk("b2b_second_wdata", last_wdata, 16'h5A5A);
    repeat (2) @(posedge clk);
    #1;
    chk("b2b_done_pulses", 16'(done_total - d0), 16'd2);

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage sequencer for the pipelined LC-3b datapath. It is the responder to the decoded control word: it consumes the memory-class opcodes (LDR, LDB, LDI, STR, STB, STI) arriving in the MEM stage and drives the data-memory port. It performs byte-lane steering, handles the two-access indirect sequences, and stalls the pipeline until the memory responds.

## Interface
- Parameters: none; all datapaths are 16 bits (lc3b_word).
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- valid_in  in  1  MEM stage holds a valid instruction
- opcode  in  4  lc3b_opcode of the MEM-stage instruction
- addr  in  16  effective address from the address adder
- store_data  in  16  SR value for stores
- dmem_rdata  in  16  read data from data memory
- dmem_resp  in  1  memory completion, one cycle per access
- dmem_address  out  16  memory address
- dmem_read  out  1  read request
- dmem_write  out  1  write request
- dmem_wmask  out  2  byte write enables (bit1 = high byte)
- dmem_wdata  out  16  write data
- load_data  out  16  registered load result to the WB stage
- done  out  1  one-cycle pulse when a memory instruction completes
- stall  out  1  freezes all upstream pipeline registers

## Operation
- Memory op = valid_in and opcode in {LDR, LDB, LDI, STR, STB, STI}. The unit decodes these itself from opcode. Every other opcode, or valid_in=0, passes through with stall=0 and done=0.
- States: IDLE, IND, ACC, DONE.
- IDLE, on a memory op:
  - Capture opcode, addr and store_data into internal registers.
  - Go to IND for LDI/STI, otherwise to ACC.
  - stall=1 in this cycle (combinational).
- IND:
  - dmem_read=1, dmem_address={addr_q[15:1],0}.
  - On dmem_resp: pointer register <= {dmem_rdata[15:1],0}; go to ACC.
- ACC:
  - The address is the pointer register for LDI/STI. Otherwise it is {addr_q[15:1],0}, except byte ops, which present addr_q unchanged.
  - Loads: dmem_read=1. Stores: dmem_write=1.
  - On dmem_resp, go to DONE. For loads, load_data is also updated:
    - LDR/LDI: dmem_rdata.
    - LDB: the selected byte is dmem_rdata[15:8] if addr_q[0]=1, else dmem_rdata[7:0]. It is sign-extended to 16 bits.
- Write encoding:
  - STR/STI: dmem_wdata=store_data_q, dmem_wmask=11.
  - STB: dmem_wdata={store_data_q[7:0],store_data_q[7:0]}, dmem_wmask=10 if addr_q[0]=1, else 01.
- DONE:
  - done=1, stall=0.
  - Unconditionally go to IDLE. valid_in is not sampled in DONE, so the same instruction is never re-accepted.
- Request hygiene:
  - dmem_read and dmem_write are never both 1.
  - dmem_wmask=00 whenever dmem_write=0.
  - Requests and address are held stable until dmem_resp.
  - dmem_resp is ignored in IDLE and DONE.
- stall=1 in IND and ACC, regardless of valid_in.

## Timing
- Reset (asynchronous, immediate) forces the following. This applies mid-access too: an outstanding request is dropped without waiting for dmem_resp.
  - state=IDLE
  - dmem_read=0, dmem_write=0, dmem_wmask=00
  - dmem_address=0, dmem_wdata=0
  - load_data=0
  - done=0
  - stall=0 (unless a memory op is presented in IDLE)
- Request outputs are decoded from state and captured registers only. They are never combinational from addr or store_data.
- dmem_resp may arrive in the first cycle a request is asserted.
- Minimum latency, from acceptance to the done cycle:
  - Direct ops: 2 cycles, with stall high for 2 cycles. Accept in cycle N, access in N+1, done in N+2.
  - LDI/STI: 3 cycles, with stall high for 3 cycles.
  - Each wait cycle without dmem_resp adds one cycle.
- load_data updates only on a load's dmem_resp. It holds its value otherwise, including through stores.
- A memory op presented in the cycle after DONE is accepted normally, giving back-to-back operation.
- Address wrap: the LDI pointer 0xFFFF is used as 0xFFFE. No carry or wrap logic exists in this block.

## Test plan
- LDR at addr=0x1003, resp on first ACC cycle, rdata=0xBEEF.
  - Required: address 0x1002 shown; load_data=0xBEEF; done in cycle N+2; stall high for exactly 2 cycles.
- LDB at addr=0x2001, rdata=0x80FF.
  - Required: load_data=0xFF80.
- LDB at addr=0x2000, same rdata.
  - Required: load_data=0xFFFF.
- STB at addr=0x3001, store_data=0x1234.
  - Required: wdata=0x3434, wmask=10, dmem_read=0.
- STR with the same data.
  - Required: wmask=11.
- LDI at addr=0x4000; the pointer read returns 0x5001; the second read returns 0x00AA. dmem_resp is delayed 2 cycles on each access.
  - Required: second access address 0x5000; load_data=0x00AA; stall high 7 cycles; single done pulse.
- Reset asserted mid-ACC of an STI.
  - Required: dmem_write falls immediately; all outputs return to reset values; a later dmem_resp in IDLE has no effect.
- ADD with valid_in=1, then back-to-back STR, STR.
  - Required: ADD gives no stall and no done.
  - Required: both stores complete; exactly two done pulses; the second STR is accepted in the cycle after the first DONE.
